// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: FSM state encoding,
// bus acknowledge levels and small helpers used by the target FSM.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Bit index of the last data bit within a byte (bits counted 0..7).
  localparam logic [3:0] LAST_BIT   = 4'd7;
  localparam logic [3:0] BYTE_DONE  = 4'd8;

  // General-call address byte (address 0, write).
  localparam logic [7:0] GENCALL_BYTE = 8'h00;

  // True when the address byte selects this target (R/W bit ignored).
  function automatic logic addr_hit(input logic [7:0] addr_byte,
                                    input logic [6:0] slave_addr);
    return addr_byte[7:1] == slave_addr;
  endfunction

  // Open-drain helper: the target pulls SDA low only to send a 0.
  function automatic logic pull_low(input logic bit_val);
    return bit_val == 1'b0;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes the raw SCL/SDA bus lines into the clk domain and derives
// SCL edge pulses plus START/STOP condition pulses from the synchronized
// levels. Synchronizers reset to 1 so an idle (pulled-up) bus causes no
// spurious edges when reset is released.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic sda_sync,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_now;
  logic                   sda_now;

  // Shift both lines through the synchronizer chain and keep one extra
  // delayed copy of each for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl};
      sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda};
      scl_prev <= scl_pipe[SYNC_STAGES-1];
      sda_prev <= sda_pipe[SYNC_STAGES-1];
    end
  end

  assign scl_now   = scl_pipe[SYNC_STAGES-1];
  assign sda_now   = sda_pipe[SYNC_STAGES-1];
  assign sda_sync  = sda_now;
  assign scl_rise  = scl_now & ~scl_prev;
  assign scl_fall  = ~scl_now & scl_prev;
  // SDA may only move while SCL has been steadily high for START/STOP.
  assign start_det = scl_now & scl_prev & sda_prev & ~sda_now;
  assign stop_det  = scl_now & scl_prev & ~sda_prev & sda_now;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target exposing a byte-wide register port. The first written byte
// after the address sets the register pointer, later written bytes are
// strobed out at the pointer, and reads return reg_rdata at the pointer.
// The pointer auto-increments after every acknowledged data byte.
// Optional feature macro: I2C_GENCALL_EN -- when defined, the general-call
// address byte 0x00 is acknowledged and the following byte is written at
// the current pointer without a pointer phase.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic       reg_we,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_state_t state, state_next;
  logic [3:0] bit_cnt, bit_cnt_next;
  logic [6:0] shift_reg, shift_next;
  logic [6:0] tx_byte, tx_next;
  logic       sda_oe, sda_oe_next;
  logic       ack_phase, ack_phase_next;
  logic       rw_bit, rw_next;
  logic [7:0] reg_addr_next;
  logic [7:0] reg_wdata_next;
  logic       reg_we_next;
  logic       busy_next;
  logic [7:0] rx_byte;
`ifdef I2C_GENCALL_EN
  logic       gencall, gencall_next;
`endif

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl      (i2c_scl),
    .sda      (i2c_sda),
    .sda_sync (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  // Open-drain output: only ever pull low or release.
  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

  // Byte as it will look once the bit sampled this clk is shifted in.
  assign rx_byte = {shift_reg, sda_s};

  // State and datapath registers; reset releases SDA and idles the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_byte   <= '0;
      sda_oe    <= 1'b0;
      ack_phase <= 1'b0;
      rw_bit    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      busy      <= 1'b0;
`ifdef I2C_GENCALL_EN
      gencall   <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      shift_reg <= shift_next;
      tx_byte   <= tx_next;
      sda_oe    <= sda_oe_next;
      ack_phase <= ack_phase_next;
      rw_bit    <= rw_next;
      reg_addr  <= reg_addr_next;
      reg_wdata <= reg_wdata_next;
      reg_we    <= reg_we_next;
      busy      <= busy_next;
`ifdef I2C_GENCALL_EN
      gencall   <= gencall_next;
`endif
    end
  end

  // Next-state logic; bus conditions take priority over data edges, and
  // ACK states use ack_phase to tell the falling edge that starts the 9th
  // clock from the one that ends it.
  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift_reg;
    tx_next        = tx_byte;
    sda_oe_next    = sda_oe;
    ack_phase_next = ack_phase;
    rw_next        = rw_bit;
    reg_addr_next  = reg_addr;
    reg_wdata_next = reg_wdata;
    reg_we_next    = 1'b0;
    busy_next      = busy;
`ifdef I2C_GENCALL_EN
    gencall_next   = gencall;
`endif

    if (stop_det) begin
      state_next     = ST_IDLE;
      sda_oe_next    = 1'b0;
      busy_next      = 1'b0;
      bit_cnt_next   = '0;
      ack_phase_next = 1'b0;
    end else if (start_det) begin
      state_next     = ST_ADDR;
      sda_oe_next    = 1'b0;
      busy_next      = 1'b0;
      bit_cnt_next   = '0;
      ack_phase_next = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_IGNORE: begin
          sda_oe_next = 1'b0;
        end

        ST_ADDR: begin
          if (scl_rise) begin
            shift_next   = rx_byte[6:0];
            bit_cnt_next = bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt_next   = '0;
              ack_phase_next = 1'b0;
              rw_next        = sda_s;
              if (addr_hit(rx_byte, SLAVE_ADDR)) begin
                state_next = ST_ADDR_ACK;
                busy_next  = 1'b1;
`ifdef I2C_GENCALL_EN
                gencall_next = 1'b0;
`endif
              end
`ifdef I2C_GENCALL_EN
              else if (rx_byte == GENCALL_BYTE) begin
                state_next   = ST_ADDR_ACK;
                busy_next    = 1'b1;
                gencall_next = 1'b1;
              end
`endif
              else begin
                state_next = ST_IGNORE;
              end
            end
          end
        end

        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe_next    = pull_low(I2C_ACK);
              ack_phase_next = 1'b1;
            end else begin
              sda_oe_next    = 1'b0;
              ack_phase_next = 1'b0;
              bit_cnt_next   = '0;
              if (state == ST_ADDR_ACK) begin
                if (rw_bit) begin
                  tx_next     = reg_rdata[6:0];
                  sda_oe_next = pull_low(reg_rdata[7]);
                  state_next  = ST_RDATA;
                end else begin
`ifdef I2C_GENCALL_EN
                  state_next = gencall ? ST_WDATA : ST_PTR;
`else
                  state_next = ST_PTR;
`endif
                end
              end else if (state == ST_PTR_ACK) begin
                state_next = ST_WDATA;
              end else begin
                reg_addr_next = reg_addr + 8'd1;
                state_next    = ST_WDATA;
              end
            end
          end
        end

        ST_PTR: begin
          if (scl_rise) begin
            shift_next   = rx_byte[6:0];
            bit_cnt_next = bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt_next   = '0;
              ack_phase_next = 1'b0;
              reg_addr_next  = rx_byte;
              state_next     = ST_PTR_ACK;
            end
          end
        end

        ST_WDATA: begin
          if (scl_rise) begin
            shift_next   = rx_byte[6:0];
            bit_cnt_next = bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt_next   = '0;
              ack_phase_next = 1'b0;
              reg_wdata_next = rx_byte;
              reg_we_next    = 1'b1;
              state_next     = ST_WDATA_ACK;
            end
          end
        end

        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == BYTE_DONE) begin
              sda_oe_next    = 1'b0;
              bit_cnt_next   = '0;
              ack_phase_next = 1'b0;
              state_next     = ST_RDATA_ACK;
            end else begin
              sda_oe_next = pull_low(tx_byte[6]);
              tx_next     = {tx_byte[5:0], 1'b0};
            end
          end
        end

        ST_RDATA_ACK: begin
          if (scl_rise && !ack_phase) begin
            if (sda_s == I2C_NACK) begin
              state_next = ST_IGNORE;
            end else begin
              reg_addr_next  = reg_addr + 8'd1;
              ack_phase_next = 1'b1;
            end
          end else if (scl_fall && ack_phase) begin
            tx_next        = reg_rdata[6:0];
            sda_oe_next    = pull_low(reg_rdata[7]);
            bit_cnt_next   = '0;
            ack_phase_next = 1'b0;
            state_next     = ST_RDATA;
          end
        end

        default: begin
          state_next  = ST_IDLE;
          sda_oe_next = 1'b0;
        end
      endcase
    end
  end

endmodule
